// File: rtl/wb_write_queue_if.sv
// Bus bundle for the register-file write-back queue: the two producer
// handshakes, the register-file write port, the forwarding probes and the
// occupancy status.
// The design side connects through the slave modport and the
// producer/consumer side through the master modport.
interface wb_write_queue_if #(
   parameter int AW    = 6,
   parameter int DW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_wa;
   logic [DW-1:0] ld_wd;
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_wa;
   logic [DW-1:0] alu_wd;
   logic          rf_busy;
   logic [AW-1:0] WA;
   logic [DW-1:0] WD;
   logic          WE1;
   logic [AW-1:0] RA1;
   logic [AW-1:0] RA2;
   logic          fwd1_hit;
   logic [DW-1:0] fwd1_data;
   logic          fwd2_hit;
   logic [DW-1:0] fwd2_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   modport slave (
      input  ld_valid, ld_wa, ld_wd, alu_valid, alu_wa, alu_wd, rf_busy, RA1, RA2,
      output ld_ready, alu_ready, WA, WD, WE1,
      output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, full, empty
   );

   modport master (
      output ld_valid, ld_wa, ld_wd, alu_valid, alu_wa, alu_wd, rf_busy, RA1, RA2,
      input  ld_ready, alu_ready, WA, WD, WE1,
      input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, full, empty
   );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue for the 64x32 register file.
// The load unit and the ALU feed one in-order FIFO; load wins when both offer.
// The FIFO head drains into a registered write port (WA/WD/WE1), at most one
// write per cycle, and the drain pauses while rf_busy is high.
// Optional macro WB_FWD_EN adds youngest-first forwarding lookups for RA1/RA2
// over the queued entries plus the output stage. Without the macro the
// forwarding outputs are tied to zero.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input logic             clk,
   input logic             rst,
   wb_write_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          we1_q, we1_d;
   logic [AW-1:0] wa_q, wa_d;
   logic [DW-1:0] wd_q, wd_d;

   // Queue storage; every entry must be visible at once for forwarding.
   logic [AW-1:0] mem_wa_q [DEPTH];
   logic [DW-1:0] mem_wd_q [DEPTH];

   logic          is_full, is_empty;
   logic          ld_push, alu_push, push, pop;
   logic [AW-1:0] push_wa;
   logic [DW-1:0] push_wd;

   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);

   // Ready depends only on registered occupancy, so a same-cycle pop never
   // frees a slot for a push.
   assign bus.ld_ready  = !is_full && !rst;
   assign bus.alu_ready = !is_full && !bus.ld_valid && !rst;

   // Transfer decode, pointer/count update and the head-to-output pop.
   always_comb begin
      ld_push  = bus.ld_valid && bus.ld_ready;
      alu_push = bus.alu_valid && bus.alu_ready;
      push     = ld_push || alu_push;
      pop      = !is_empty && !bus.rf_busy;
      push_wa  = ld_push ? bus.ld_wa : bus.alu_wa;
      push_wd  = ld_push ? bus.ld_wd : bus.alu_wd;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      we1_d    = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         we1_d    = 1'b1;
         wa_d     = mem_wa_q[rd_ptr_q];
         wd_d     = mem_wd_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and output-stage registers; reset discards every queued entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we1_q    <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we1_q    <= we1_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
      end
   end

   // Entry write at the tail; push is already blocked while rst is high.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wa_q[wr_ptr_q] <= push_wa;
         mem_wd_q[wr_ptr_q] <= push_wd;
      end
   end

   assign bus.WA    = wa_q;
   assign bus.WD    = wd_q;
   assign bus.WE1   = we1_q;
   assign bus.count = count_q;
   assign bus.full  = is_full;
   assign bus.empty = is_empty;

`ifdef WB_FWD_EN
   // Entries viewed in age order: slot 0 is the head, higher slots are younger.
   logic          age_valid [DEPTH];
   logic [AW-1:0] age_wa    [DEPTH];
   logic [DW-1:0] age_wd    [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_valid[gi] = (CW'(gi) < count_q);
      assign age_wa[gi]    = mem_wa_q[rd_ptr_q + PW'(gi)];
      assign age_wd[gi]    = mem_wd_q[rd_ptr_q + PW'(gi)];
   end

   // Youngest match wins: start from the output stage, then let each younger
   // queue slot override an older one.
   always_comb begin
      bus.fwd1_hit  = 1'b0;
      bus.fwd1_data = '0;
      bus.fwd2_hit  = 1'b0;
      bus.fwd2_data = '0;
      if (we1_q && (wa_q == bus.RA1)) begin
         bus.fwd1_hit  = 1'b1;
         bus.fwd1_data = wd_q;
      end
      if (we1_q && (wa_q == bus.RA2)) begin
         bus.fwd2_hit  = 1'b1;
         bus.fwd2_data = wd_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k] && (age_wa[k] == bus.RA1)) begin
            bus.fwd1_hit  = 1'b1;
            bus.fwd1_data = age_wd[k];
         end
         if (age_valid[k] && (age_wa[k] == bus.RA2)) begin
            bus.fwd2_hit  = 1'b1;
            bus.fwd2_data = age_wd[k];
         end
      end
   end
`else
   // Probes are not looked up in this build.
   logic unused_fwd_probe;
   assign unused_fwd_probe = ^{bus.RA1, bus.RA2};
   assign bus.fwd1_hit  = 1'b0;
   assign bus.fwd1_data = '0;
   assign bus.fwd2_hit  = 1'b0;
   assign bus.fwd2_data = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: a table of per-cycle input/expected-output rows,
// followed by a hand-written wrap-around sequence checked with a scoreboard.
module tb_wb_write_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_write_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();
   wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic          rst;
      logic          lv;
      logic [AW-1:0] lwa;
      logic [DW-1:0] lwd;
      logic          av;
      logic [AW-1:0] awa;
      logic [DW-1:0] awd;
      logic          busy;
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic          e_lr;
      logic          e_ar;
      logic          e_we;
      logic [AW-1:0] e_wa;
      logic [DW-1:0] e_wd;
      int            e_cnt;
      logic          e_f1h;
      logic [DW-1:0] e_f1d;
      logic          e_f2h;
      logic [DW-1:0] e_f2d;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   task automatic add(input logic r, input logic lv, input int lwa, input logic [DW-1:0] lwd,
                      input logic av, input int awa, input logic [DW-1:0] awd, input logic busy,
                      input int ra1, input int ra2, input logic lr, input logic ar, input logic we,
                      input int wa, input logic [DW-1:0] wd, input int cnt,
                      input logic f1h, input logic [DW-1:0] f1d, input logic f2h, input logic [DW-1:0] f2d);
      vec_t v;
      v.rst = r; v.lv = lv; v.lwa = AW'(lwa); v.lwd = lwd;
      v.av = av; v.awa = AW'(awa); v.awd = awd; v.busy = busy;
      v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
      v.e_lr = lr; v.e_ar = ar; v.e_we = we; v.e_wa = AW'(wa); v.e_wd = wd; v.e_cnt = cnt;
      v.e_f1h = f1h; v.e_f1d = f1d; v.e_f2h = f2h; v.e_f2d = f2d;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   logic [AW+DW-1:0] sb[$];
   int writes;

   initial begin
      rst = 1'b1;
      bus.ld_valid = 1'b0; bus.ld_wa = '0; bus.ld_wd = '0;
      bus.alu_valid = 1'b0; bus.alu_wa = '0; bus.alu_wd = '0;
      bus.rf_busy = 1'b0; bus.RA1 = '0; bus.RA2 = '0;

      //   rst lv lwa lwd     av awa awd            busy ra1 ra2 | lr ar we wa wd            cnt f1h f1d          f2h f2d
      // single ALU result
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 0, 0, 0,             0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 5, 32'hDEADBEEF,   0, 0, 0,   1, 1, 0, 0, 0,             0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 5, 0,   1, 1, 0, 0, 0,             1, 1, 32'hDEADBEEF,  0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 5, 0,   1, 1, 1, 5, 32'hDEADBEEF,  0, 1, 32'hDEADBEEF,  0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 5, 0,   1, 1, 0, 5, 32'hDEADBEEF,  0, 0, 0,             0, 0);
      // arbitration: load before ALU
      add(0, 1, 3, 32'h11,  1, 4, 32'h22,         0, 0, 0,   1, 0, 0, 5, 32'hDEADBEEF,  0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 4, 32'h22,         0, 0, 0,   1, 1, 0, 5, 32'hDEADBEEF,  1, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 1, 3, 32'h11,        1, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 1, 4, 32'h22,        0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 0, 4, 32'h22,        0, 0, 0,             0, 0);
      // fill under rf_busy with forwarding probes, then drain
      add(0, 0, 0, 0,       1, 7, 32'h1,          1, 0, 0,   1, 1, 0, 4, 32'h22,        0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 9, 32'h2,          1, 7, 0,   1, 1, 0, 4, 32'h22,        1, 1, 32'h1,         0, 0);
      add(0, 0, 0, 0,       1, 7, 32'h3,          1, 7, 9,   1, 1, 0, 4, 32'h22,        2, 1, 32'h1,         1, 32'h2);
      add(0, 0, 0, 0,       1, 1, 32'h55,         1, 7, 9,   1, 1, 0, 4, 32'h22,        3, 1, 32'h3,         1, 32'h2);
      add(0, 0, 0, 0,       1, 2, 32'h66,         1, 8, 9,   0, 0, 0, 4, 32'h22,        4, 0, 0,             1, 32'h2);
      add(0, 0, 0, 0,       1, 2, 32'h66,         0, 7, 1,   0, 0, 0, 4, 32'h22,        4, 1, 32'h3,         1, 32'h55);
      add(0, 0, 0, 0,       1, 2, 32'h66,         0, 7, 9,   1, 1, 1, 7, 32'h1,         3, 1, 32'h3,         1, 32'h2);
      add(0, 0, 0, 0,       0, 0, 0,              0, 7, 2,   1, 1, 1, 9, 32'h2,         3, 1, 32'h3,         1, 32'h66);
      add(0, 0, 0, 0,       0, 0, 0,              0, 7, 9,   1, 1, 1, 7, 32'h3,         2, 1, 32'h3,         0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 1, 1, 32'h55,        1, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 1, 2, 32'h66,        0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 0, 0,   1, 1, 0, 2, 32'h66,        0, 0, 0,             0, 0);
      // reset mid-operation: 3 queued, WE1 high, ALU offering during reset
      add(0, 0, 0, 0,       1, 10, 32'hA0,        1, 0, 0,   1, 1, 0, 2, 32'h66,        0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 11, 32'hA1,        1, 0, 0,   1, 1, 0, 2, 32'h66,        1, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 12, 32'hA2,        1, 0, 0,   1, 1, 0, 2, 32'h66,        2, 0, 0,             0, 0);
      add(0, 0, 0, 0,       1, 13, 32'hA3,        1, 0, 0,   1, 1, 0, 2, 32'h66,        3, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 11, 0,  0, 0, 0, 2, 32'h66,        4, 1, 32'hA1,        0, 0);
      add(1, 0, 0, 0,       1, 20, 32'hBB,        0, 10, 13, 0, 0, 1, 10, 32'hA0,       3, 1, 32'hA0,        1, 32'hA3);
      add(0, 0, 0, 0,       0, 0, 0,              0, 10, 13, 1, 1, 0, 0, 0,             0, 0, 0,             0, 0);
      add(0, 0, 0, 0,       0, 0, 0,              0, 10, 13, 1, 1, 0, 0, 0,             0, 0, 0,             0, 0);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         logic f1h, f2h;
         logic [DW-1:0] f1d, f2d;
         v = vecs[i];
         rst = v.rst;
         bus.ld_valid = v.lv; bus.ld_wa = v.lwa; bus.ld_wd = v.lwd;
         bus.alu_valid = v.av; bus.alu_wa = v.awa; bus.alu_wd = v.awd;
         bus.rf_busy = v.busy; bus.RA1 = v.ra1; bus.RA2 = v.ra2;
         f1h = FWD ? v.e_f1h : 1'b0;
         f1d = FWD ? v.e_f1d : '0;
         f2h = FWD ? v.e_f2h : 1'b0;
         f2d = FWD ? v.e_f2d : '0;
         @(negedge clk);
         chk("ready", i, 64'({bus.ld_ready, bus.alu_ready}), 64'({v.e_lr, v.e_ar}));
         chk("wport", i, 64'({bus.WE1, bus.WA, bus.WD}), 64'({v.e_we, v.e_wa, v.e_wd}));
         chk("occupancy", i, 64'({bus.count, bus.full, bus.empty}),
             64'({CW'(v.e_cnt), (v.e_cnt == DEPTH), (v.e_cnt == 0)}));
         chk("fwd1", i, 64'({bus.fwd1_hit, bus.fwd1_data}), 64'({f1h, f1d}));
         chk("fwd2", i, 64'({bus.fwd2_hit, bus.fwd2_data}), 64'({f2h, f2d}));
         $display("row %0d: rst=%0b lv=%0b av=%0b busy=%0b -> we1=%0b wa=%0d wd=%h count=%0d",
                  i, v.rst, v.lv, v.av, v.busy, bus.WE1, bus.WA, bus.WD, bus.count);
         @(posedge clk);
         #1;
      end

      // Wrap-around: 10 pushes interleaved with idle cycles; pointers wrap twice.
      rst = 1'b0;
      bus.ld_valid = 1'b0; bus.rf_busy = 1'b0;
      writes = 0;
      for (int i = 0; i < 24; i++) begin
         bus.alu_valid = (i < 20) && (i % 2 == 0);
         bus.alu_wa = AW'(20 + i / 2);
         bus.alu_wd = 32'hC0DE0000 + 32'(i / 2);
         if (bus.alu_valid) sb.push_back({bus.alu_wa, bus.alu_wd});
         @(negedge clk);
         chk("wrap_count_le2", 100 + i, 64'(bus.count > CW'(2)), 64'(0));
         if (bus.WE1) begin
            if (sb.size() == 0) begin
               chk("wrap_stray_we1", 100 + i, 64'(bus.WE1), 64'(0));
            end else begin
               logic [AW+DW-1:0] exp_e;
               exp_e = sb.pop_front();
               chk("wrap_write", 100 + i, 64'({bus.WA, bus.WD}), 64'(exp_e));
               writes++;
            end
         end
         $display("wrap %0d: push=%0b we1=%0b wa=%0d wd=%h count=%0d",
                  i, bus.alu_valid, bus.WE1, bus.WA, bus.WD, bus.count);
         @(posedge clk);
         #1;
      end
      chk("wrap_write_total", 200, 64'(writes), 64'(10));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
